// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator drain path: width codes, drain FSM
// states, the skid-FIFO entry layout and the saturation ceiling per width.
package accumulator_pkg;

  localparam logic [1:0] BW_2 = 2'd0;
  localparam logic [1:0] BW_4 = 2'd1;
  localparam logic [1:0] BW_8 = 2'd2;

  localparam int OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } drain_entry_t;

  // Largest unsigned activation representable at the given width; code 3 folds onto 2b.
  function automatic logic [OUT_WIDTH-1:0] sat_max(input logic [1:0] bw);
    case (bw)
      BW_4:    sat_max = 8'd15;
      BW_8:    sat_max = 8'd255;
      default: sat_max = 8'd3;
    endcase
  endfunction

endpackage

// File: rtl/accumulator_drain_fifo.sv
// Small power-of-two synchronous FIFO holding requantized activations and
// their end-of-tile flag between the back-buffer read and the output port.
module drain_fifo
  import accumulator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  drain_entry_t           push_entry,
  input  logic                   pop,
  output drain_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  drain_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; only pointers and count do, and the
  // head is forced to zero while empty so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/accumulator_drain.sv
// Drains one tile from the accumulator back buffer: sequential reads, ReLU +
// shift + saturate to the latched activation width, credit-limited streaming.
module accumulator_drain
  import accumulator_pkg::*;
#(
  parameter int BUFFER_WIDTH           = 8,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  parameter int FIFO_DEPTH             = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [1:0]                          bitwidth,
  input  logic [3:0]                          shift,
  output logic [$clog2(BUFFER_WIDTH)-1:0]     back_buffer_bank_entry,
  output logic                                back_buffer_read_enable,
  input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0] back_buffer_data_read,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);

  localparam int AW = $clog2(BUFFER_WIDTH);
  localparam int DW = SMALLEST_ELEMENT_WIDTH * 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] LAST_ENTRY = AW'(BUFFER_WIDTH - 1);

  drain_state_t  state;
  drain_state_t  state_next;
  logic [AW-1:0] addr;
  logic [1:0]    bw_q;
  logic [3:0]    shift_q;
  logic          in_flight;
  logic          in_flight_last;

  drain_entry_t  push_entry;
  drain_entry_t  fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic [CW:0]   credit_used;
  logic          credit_ok;

  // Negative sums clamp to zero, so the shift only ever sees non-negative values
  // and a logical shift matches the arithmetic one.
  function automatic logic [OUT_WIDTH-1:0] requantize(
    input logic [DW-1:0] x,
    input logic [3:0]    sh,
    input logic [1:0]    bw
  );
    logic [DW-1:0]        r;
    logic [OUT_WIDTH-1:0] m;
    m = sat_max(bw);
    r = x[DW-1] ? '0 : (x >> sh);
    requantize = (r > DW'(m)) ? m : r[OUT_WIDTH-1:0];
  endfunction

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head.data;
  assign out_last  = fifo_head.last;
  assign pop       = out_valid && out_ready;

  // A pop this cycle frees its slot before the new read can land, which keeps
  // one element per cycle flowing with only two FIFO entries.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(in_flight) - (CW+1)'(pop);
  assign credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH)) && !(fifo_full && !pop);

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next              = state;
    back_buffer_read_enable = 1'b0;
    done                    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (credit_ok) begin
          back_buffer_read_enable = 1'b1;
          if (addr == LAST_ENTRY) state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fifo_empty && !in_flight) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign back_buffer_bank_entry = addr;
  assign busy                   = (state != S_IDLE) && !done;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      addr           <= '0;
      bw_q           <= BW_2;
      shift_q        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state          <= state_next;
      in_flight      <= back_buffer_read_enable;
      in_flight_last <= back_buffer_read_enable && (addr == LAST_ENTRY);
      if (state == S_IDLE && start) begin
        addr    <= '0;
        bw_q    <= bitwidth;
        shift_q <= shift;
      end else if (back_buffer_read_enable) begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_comb begin
    push_entry.last = in_flight_last;
    push_entry.data = requantize(back_buffer_data_read, shift_q, bw_q);
  end

  drain_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain: a one-cycle-latency back-buffer model
// feeds the DUT and every drained tile is compared against hand-computed values.
module tb_accumulator_drain;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_CYC    = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  bitwidth;
  logic [3:0]  shift;
  logic [2:0]  back_buffer_bank_entry;
  logic        back_buffer_read_enable;
  logic [15:0] back_buffer_data_read;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] bank [8];
  logic [7:0]  exp_mem [8];
  logic [7:0]  got_data [8];
  logic [7:0]  last_mask;
  logic [15:0] ready_pat;
  int          first_re_cyc, first_valid_cyc, last_cyc, done_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  accumulator_drain #(
    .BUFFER_WIDTH(8),
    .SMALLEST_ELEMENT_WIDTH(4),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .start                  (start),
    .bitwidth               (bitwidth),
    .shift                  (shift),
    .back_buffer_bank_entry (back_buffer_bank_entry),
    .back_buffer_read_enable(back_buffer_read_enable),
    .back_buffer_data_read  (back_buffer_data_read),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_last               (out_last),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (back_buffer_read_enable) back_buffer_data_read <= bank[back_buffer_bank_entry];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Starts a drain, follows it cycle by cycle, then compares against exp_mem.
  task automatic run_drain(input string tag, input logic [1:0] bw, input logic [3:0] sh,
                           input bit use_pattern, input bit restart);
    int n_out = 0, n_done = 0, next_addr = 0, addr_err = 0, extra_re = 0;
    int stable_err = 0, busy_err = 0, outstanding = 0, max_out = 0, tail = 0;
    logic busy_at_done = 1'b1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    first_re_cyc = -1; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
    last_mask = '0;
    for (int i = 0; i < 8; i++) got_data[i] = '0;

    @(posedge clk); #1;
    start = 1'b1; bitwidth = bw; shift = sh; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bitwidth = ~bw; shift = ~sh;
    for (int cyc = 1; cyc < MAX_CYC; cyc++) begin
      out_ready = use_pattern ? ready_pat[cyc % 16] : 1'b1;
      start     = restart && (cyc == 4);
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stable_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (back_buffer_read_enable) begin
        if (n_done > 0) extra_re++;
        else begin
          if (back_buffer_bank_entry !== 3'(next_addr)) addr_err++;
          if (first_re_cyc < 0) first_re_cyc = cyc;
          next_addr++;
        end
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (n_out < 8) begin
          got_data[n_out] = out_data;
          last_mask[n_out] = out_last;
        end
        if (out_last) last_cyc = cyc;
        n_out++;
      end
      outstanding += int'(back_buffer_read_enable) - int'(out_valid && out_ready);
      if (outstanding > max_out) max_out = outstanding;
      if (n_done == 0 && !done && !busy) busy_err++;
      if (done) begin
        if (n_done == 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
        n_done++;
      end
      if (n_done > 0) tail++;
      if (tail > 4) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;

    check({tag, " output count"}, n_out, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s data[%0d]", tag, i), got_data[i], exp_mem[i]);
    check({tag, " last flags"}, last_mask, 8'h80);
    check({tag, " done pulses"}, n_done, 1);
    check({tag, " read order errors"}, addr_err, 0);
    check({tag, " reads issued"}, next_addr, 8);
    check({tag, " reads after done"}, extra_re, 0);
    check({tag, " stall stability errors"}, stable_err, 0);
    check({tag, " outstanding within depth"}, 32'(max_out <= FIFO_DEPTH), 1);
    check({tag, " busy gaps"}, busy_err, 0);
    check({tag, " busy low with done"}, busy_at_done, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; bitwidth = '0; shift = '0; out_ready = 1'b0;
    ready_pat = 16'b1001_1000_0110_0001;
    for (int i = 0; i < 8; i++) bank[i] = 16'(i + 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset bank_entry", back_buffer_bank_entry, 0);
    check("reset read_enable", back_buffer_read_enable, 0);
    check("reset out_data", out_data, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    reset_n = 1'b1;

    // Ramp 1..8 at 4b with continuous ready: exact cycle timing.
    exp_mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_drain("ramp", 2'd1, 4'd0, 1'b0, 1'b0);
    check("ramp first read cycle", first_re_cyc, 1);
    check("ramp first valid cycle", first_valid_cyc, 3);
    check("ramp last cycle", last_cyc, 10);
    check("ramp done cycle", done_cyc, 11);

    // Requantization corners.
    bank = '{16'hFFFB, 16'd300, 16'd16, 16'd15, 16'd12, 16'd9, 16'h7FFF, 16'h8000};
    exp_mem = '{8'd0, 8'd15, 8'd15, 8'd15, 8'd12, 8'd9, 8'd15, 8'd0};
    run_drain("bw4 sh0", 2'd1, 4'd0, 1'b0, 1'b0);
    exp_mem = '{8'd0, 8'd255, 8'd16, 8'd15, 8'd12, 8'd9, 8'd255, 8'd0};
    run_drain("bw8 sh0", 2'd2, 4'd0, 1'b0, 1'b0);
    exp_mem = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd3, 8'd0};
    run_drain("bw2 sh2", 2'd0, 4'd2, 1'b0, 1'b0);
    exp_mem = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};
    run_drain("bw3 sh0", 2'd3, 4'd0, 1'b0, 1'b0);
    exp_mem = '{8'd0, 8'd18, 8'd1, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0};
    run_drain("bw8 sh4", 2'd2, 4'd4, 1'b0, 1'b0);

    // Backpressure and an ignored second start.
    for (int i = 0; i < 8; i++) bank[i] = 16'(i + 1);
    exp_mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_drain("backpressure", 2'd2, 4'd0, 1'b1, 1'b0);
    run_drain("restart ignored", 2'd2, 4'd0, 1'b0, 1'b1);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    start = 1'b1; bitwidth = 2'd2; shift = 4'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort bank_entry", back_buffer_bank_entry, 0);
    check("abort read_enable", back_buffer_read_enable, 0);
    check("abort out_data", out_data, 0);
    check("abort out_valid", out_valid, 0);
    check("abort out_last", out_last, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_drain("after abort", 2'd2, 4'd0, 1'b0, 1'b0);
    check("after abort first valid cycle", first_valid_cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
